// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory between the CPU and the host loader.
// Each access takes three cycles (IDLE, ISSUE, RESP). A bounded lock keeps the bus with one requester.
module mem_arbiter #(
    parameter int WIDTH    = 8,
    parameter int AWIDTH   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic              cpu_ack,
    output logic              host_ack,
    output logic [WIDTH-1:0]  rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam int   CW   = $clog2(LOCK_MAX + 1);
    localparam logic CPU  = 1'b0;
    localparam logic HOST = 1'b1;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_winner_q, last_winner_d;
    logic                lock_act_q, lock_act_d;
    logic                lock_owner_q, lock_owner_d;
    logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

    logic own_req, own_lock, locked_hold, grant, grant_who, who_lock;

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_winner_d = last_winner_q;
        lock_act_d    = lock_act_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        grant         = 1'b0;
        grant_who     = CPU;

        own_req     = (lock_owner_q == HOST) ? host_req  : cpu_req;
        own_lock    = (lock_owner_q == HOST) ? host_lock : cpu_lock;
        locked_hold = lock_act_q && own_lock && (lock_cnt_q != CW'(LOCK_MAX));
        who_lock    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (locked_hold) begin
                    grant     = own_req;
                    grant_who = lock_owner_q;
                end else if (cpu_req && host_req) begin
                    // After a forced release last_winner is the owner, so the other side wins the tie.
                    grant     = 1'b1;
                    grant_who = (last_winner_q == HOST) ? CPU : HOST;
                end else if (cpu_req || host_req) begin
                    grant     = 1'b1;
                    grant_who = host_req ? HOST : CPU;
                end

                who_lock = (grant_who == HOST) ? host_lock : cpu_lock;

                if (grant) begin
                    winner_d    = grant_who;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (grant_who == HOST) ? host_we    : cpu_we;
                    mem_addr_d  = (grant_who == HOST) ? host_addr  : cpu_addr;
                    mem_wdata_d = (grant_who == HOST) ? host_wdata : cpu_wdata;
                    state_d     = S_ISSUE;
                    if (locked_hold) begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end else if (who_lock) begin
                        lock_act_d   = 1'b1;
                        lock_owner_d = grant_who;
                        lock_cnt_d   = CW'(1);
                    end else begin
                        lock_act_d = 1'b0;
                        lock_cnt_d = '0;
                    end
                end else if (!locked_hold) begin
                    lock_act_d = 1'b0;
                    lock_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = S_RESP;
            end
            S_RESP: begin
                last_winner_d = winner_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            winner_q      <= CPU;
            last_winner_q <= HOST;
            lock_act_q    <= 1'b0;
            lock_owner_q  <= CPU;
            lock_cnt_q    <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            lock_act_q    <= lock_act_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = (state_q == S_RESP) && (winner_q == CPU);
    assign host_ack  = (state_q == S_RESP) && (winner_q == HOST);
    assign rdata     = (state_q == S_RESP) ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_ack;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte memory model answers accesses and ack events
// (requester, cycle, read data) are scored against hand-computed expectations.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_lock, host_req, host_we, host_lock;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic       cpu_ack, host_ack, mem_en, mem_we, cpu_stall, busy;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [7:0]  rd_q;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(8), .AWIDTH(8), .LOCK_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .cpu_ack(cpu_ack), .host_ack(host_ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .busy(busy), .dbg_state(dbg_state)
    );

    // Synchronous memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd_q <= mem[mem_addr];
        end
    end
    assign mem_rdata = rd_q;

    function automatic logic [7:0] exp_byte(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    function automatic logic [16:0] ev(input logic who, input int cyc, input logic [7:0] d);
        return {who, 8'(cyc), d};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Runs n cycles starting just after a rising edge; mode 1 steps a 4-byte CPU fetch.
    task automatic run(input int n, input int mode);
        int  ncpu;
        logic seen_cpu, seen_host;
        ncpu = 0;
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen_cpu  = cpu_ack;
            seen_host = host_ack;
            if (seen_cpu) begin
                got_q.push_back(ev(1'b0, i, rdata));
                ncpu++;
            end
            if (seen_host) got_q.push_back(ev(1'b1, i, rdata));
            @(posedge clk);
            #1;
            if (mode == 1) begin
                if (seen_cpu) begin
                    if (ncpu == 4) begin
                        cpu_req  = 0;
                        cpu_lock = 0;
                    end else begin
                        cpu_addr = 8'(ncpu);
                    end
                end
                if (seen_host) host_req = 0;
            end
        end
    endtask

    task automatic score(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = exp_byte(8'(i));
        rd_q = 8'h00;

        // Reset state
        reset = 1'b1;
        clear_inputs();
        #1;
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_acks", {cpu_ack, host_ack}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_stall", cpu_stall, 0);
        cpu_req = 1;
        #1 check_eq("rst_stall_follows", cpu_stall, 1);

        // CPU read alone
        do_reset();
        cpu_req = 1; cpu_addr = 8'h10;
        @(negedge clk);
        check_eq("rd_n_stall", cpu_stall, 1);
        check_eq("rd_n_mem_en", mem_en, 0);
        check_eq("rd_n_busy", busy, 0);
        @(negedge clk);
        check_eq("rd_n1_mem_en", mem_en, 1);
        check_eq("rd_n1_mem_we", mem_we, 0);
        check_eq("rd_n1_addr", mem_addr, 8'h10);
        check_eq("rd_n1_stall", cpu_stall, 1);
        check_eq("rd_n1_ack", cpu_ack, 0);
        @(negedge clk);
        check_eq("rd_n2_ack", cpu_ack, 1);
        check_eq("rd_n2_host_ack", host_ack, 0);
        check_eq("rd_n2_rdata", rdata, 8'hA5);
        check_eq("rd_n2_stall", cpu_stall, 0);
        check_eq("rd_n2_mem_en", mem_en, 0);
        @(posedge clk);
        #1 cpu_req = 0;
        @(negedge clk);
        check_eq("rd_n3_busy", busy, 0);
        check_eq("rd_n3_rdata", rdata, 0);
        check_eq("rd_n3_ack", cpu_ack, 0);

        // Tie without locks alternates, CPU first
        do_reset();
        cpu_req = 1; cpu_addr = 8'h20; host_req = 1; host_addr = 8'h21;
        run(12, 0);
        exp_q.delete();
        exp_q.push_back(ev(1'b0, 2, 8'h7A));
        exp_q.push_back(ev(1'b1, 5, 8'h7B));
        exp_q.push_back(ev(1'b0, 8, 8'h7A));
        exp_q.push_back(ev(1'b1, 11, 8'h7B));
        score("tie");

        // CPU four-byte fetch under lock holds off a waiting host
        do_reset();
        cpu_req = 1; cpu_lock = 1; cpu_addr = 8'h00; host_req = 1; host_addr = 8'h40;
        run(16, 1);
        exp_q.delete();
        exp_q.push_back(ev(1'b0, 2, 8'h5A));
        exp_q.push_back(ev(1'b0, 5, 8'h5B));
        exp_q.push_back(ev(1'b0, 8, 8'h58));
        exp_q.push_back(ev(1'b0, 11, 8'h59));
        exp_q.push_back(ev(1'b1, 14, 8'h1A));
        score("fetch");

        // Host lock limit: CPU wins first tie, then 16 locked host grants, one CPU, host re-locks
        do_reset();
        cpu_req = 1; cpu_addr = 8'h20; host_req = 1; host_lock = 1; host_addr = 8'h21;
        run(57, 0);
        exp_q.delete();
        exp_q.push_back(ev(1'b0, 2, 8'h7A));
        for (int k = 0; k < 16; k++) exp_q.push_back(ev(1'b1, 5 + 3 * k, 8'h7B));
        exp_q.push_back(ev(1'b0, 53, 8'h7A));
        exp_q.push_back(ev(1'b1, 56, 8'h7B));
        score("lockmax");

        // Host write
        do_reset();
        host_req = 1; host_we = 1; host_addr = 8'h3F; host_wdata = 8'h5C;
        @(negedge clk);
        check_eq("wr_n_mem_en", mem_en, 0);
        @(negedge clk);
        check_eq("wr_n1_mem_en", mem_en, 1);
        check_eq("wr_n1_mem_we", mem_we, 1);
        check_eq("wr_n1_addr", mem_addr, 8'h3F);
        check_eq("wr_n1_wdata", mem_wdata, 8'h5C);
        check_eq("wr_n1_ack", host_ack, 0);
        @(negedge clk);
        check_eq("wr_n2_ack", host_ack, 1);
        check_eq("wr_n2_cpu_ack", cpu_ack, 0);
        check_eq("wr_n2_mem_en", mem_en, 0);
        check_eq("wr_n2_mem_we", mem_we, 0);
        check_eq("wr_mem_content", mem[8'h3F], 8'h5C);
        @(posedge clk);
        #1 clear_inputs();

        // Reset during ISSUE abandons the access; a later read completes
        do_reset();
        cpu_req = 1; cpu_addr = 8'h10;
        @(negedge clk);
        @(posedge clk);
        #1 check_eq("rsti_mem_en_before", mem_en, 1);
        reset = 1'b1;
        #1;
        check_eq("rsti_mem_en_async", mem_en, 0);
        check_eq("rsti_busy", busy, 0);
        @(negedge clk);
        check_eq("rsti_no_ack", {cpu_ack, host_ack}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        run(4, 0);
        exp_q.delete();
        exp_q.push_back(ev(1'b0, 2, 8'hA5));
        score("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single byte-wide data/instruction memory between the multicycle CPU controller/datapath and the host loader/debug port. Each requester issues one byte access at a time with a req/ack handshake. The arbiter serialises the accesses onto the memory with round-robin fairness. A bounded lock lets the CPU keep its four-byte instruction fetch, and the host keep a load burst, uninterrupted.

## Interface
- WIDTH, 8, data width of memory and both requester ports
- AWIDTH, 8, address width
- LOCK_MAX, 16, max consecutive locked grants before forced release (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req, cpu_we, cpu_lock  in  1 each  CPU request, write enable, hold-bus hint (high during FETCH1–FETCH4)
- cpu_addr  in  AWIDTH  CPU address
- cpu_wdata  in  WIDTH  CPU write data
- host_req, host_we, host_lock  in  1 each  host request, write enable, burst hold
- host_addr  in  AWIDTH  host address
- host_wdata  in  WIDTH  host write data
- cpu_ack, host_ack  out  1 each  one-cycle completion pulse
- rdata  out  WIDTH  read data, valid only while an ack is high
- mem_en, mem_we  out  1 each  memory strobe/write enable (registered)
- mem_addr  out  AWIDTH  registered memory address
- mem_wdata  out  WIDTH  registered memory write data
- mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_en
- cpu_stall  out  1  high while cpu_req high and no cpu_ack this cycle (used to gate controller state advance)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE: if a lock is held, grant only the lock owner. Otherwise:
  - one req high → grant it;
  - both high → grant the requester that did not win last (last_winner resets to HOST, so the CPU wins the first tie).
- On grant, register the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set mem_en, and go to ISSUE. No req → stay IDLE.
- ISSUE: mem_en high for exactly this cycle. Go to RESP.
- RESP: pulse the winner's ack. rdata = mem_rdata (combinational pass-through; don't-care for writes). Update last_winner. Go to IDLE.
- Requesters hold req/addr/we/wdata stable from assertion until their ack cycle. The arbiter samples inputs only in IDLE.
- Lock:
  - Owner is set when the winner's lock input is high in the grant cycle. Lock_cnt increments per locked grant.
  - Lock is released in IDLE when the owner's lock input is low, or when lock_cnt = LOCK_MAX.
  - On a LOCK_MAX release, the other requester wins that IDLE if it is requesting. Otherwise the owner may re-acquire with lock_cnt reset to 1.
  - While locked with the owner's req low, the arbiter idles; the other requester waits.
- rdata = 0 when no ack is high.
- Simultaneous ack to both requesters is impossible; at most one grant is in flight.

## Timing
- Reset values:
  - state IDLE; all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, acks, rdata, busy; cpu_stall follows cpu_req);
  - lock cleared, lock_cnt 0, last_winner HOST.
- Latency: req sampled in IDLE cycle N → mem_en in cycle N+1 → ack and rdata in cycle N+2 → IDLE in N+3.
- Throughput: one access per 3 cycles. A CPU four-byte fetch under lock takes 12 cycles.
- A requester may drop or re-present req on the edge ending its ack cycle. A new req is sampled in N+3.
- Reset asserted mid-operation: immediate return to IDLE, with mem_en/mem_we forced low asynchronously. An in-flight access is abandoned with no ack. A write already sampled by memory in ISSUE is not undone.
- A req deasserted before ack violates the protocol; the arbiter still completes the access and pulses ack.

## Test plan
- CPU read alone: cpu_req=1, addr=0x10, mem_rdata=0xA5 → mem_en at N+1 with mem_addr=0x10, cpu_ack and rdata=0xA5 at N+2, cpu_stall high N..N+1.
- Tie, no locks: both req held continuously → grants alternate CPU, HOST, CPU, HOST…; each ack is 3 cycles apart.
- CPU fetch lock: cpu_lock=1 for 4 reads at 0x00–0x03 while host_req=1 → 4 CPU acks (12 cycles) before the first host grant.
- Host lock limit: host_lock held, both req, LOCK_MAX=16 → 16 host grants, then exactly 1 CPU grant, then host re-locks.
- Host write: host_we=1, addr=0x3F, wdata=0x5C → mem_en=1, mem_we=1, mem_addr=0x3F, mem_wdata=0x5C for one cycle; host_ack next cycle.
- Reset during ISSUE → mem_en low the same cycle, no ack, state IDLE; a CPU read afterward completes normally.
